sram_port_arbiter: RTL and testbench

Shares the single external SRAM port among the Milestone 2 requester units: fetch, write, and an optional third requester. It sits between those units and the top-level SRAM pins. Arbitration is round-robin, and a requester keeps ownership for a burst. The arbiter tags every read issued on the port and asserts a per-requester read-valid strobe exactly READ_LAT cycles after the read was issued. Top-level controllers therefore no longer mux the SRAM port by state.

---
 rtl/sram_arb_pkg.sv | 12 +
 rtl/sram_port_arbiter_if.sv | 23 ++
 rtl/sram_arb_rr_pick.sv | 21 ++
 rtl/sram_port_arbiter.sv | 91 +++++++++
 tb/tb_sram_port_arbiter.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and constants for the SRAM port arbiter.
package sram_arb_pkg;
    typedef enum logic {ARB_IDLE, ARB_OWNED} arb_state_type;
    localparam int REQ_FETCH = 0;
    localparam int REQ_WRITE = 1;
    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;
    typedef struct packed {
        logic       valid;
        logic [1:0] owner;
    } arb_tag_t;
endpackage

// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: requester-side bus and muxed SRAM pins of the arbiter.
interface sram_port_arbiter_if import sram_arb_pkg::*; #(parameter int N_REQ = 2);
    logic [N_REQ-1:0]             req;
    logic [N_REQ-1:0]             lock;
    logic [N_REQ*SRAM_ADDR_W-1:0] req_address;
    logic [N_REQ-1:0]             req_we_n;
    logic [N_REQ*SRAM_DATA_W-1:0] req_write_data;
    logic [N_REQ-1:0]             gnt;
    logic [N_REQ-1:0]             rd_valid;
    logic [1:0]                   owner;
    logic                         busy;
    logic [SRAM_ADDR_W-1:0]       SRAM_address;
    logic                         SRAM_we_n;
    logic [SRAM_DATA_W-1:0]       SRAM_write_data;
    modport master (
        output req, lock, req_address, req_we_n, req_write_data,
        input  gnt, rd_valid, owner, busy, SRAM_address, SRAM_we_n, SRAM_write_data
    );
    modport slave (
        input  req, lock, req_address, req_we_n, req_write_data,
        output gnt, rd_valid, owner, busy, SRAM_address, SRAM_we_n, SRAM_write_data
    );
endinterface

// File: rtl/sram_arb_rr_pick.sv
// sram_arb_rr_pick: combinational round-robin pick starting after last_owner.
module sram_arb_rr_pick import sram_arb_pkg::*; #(parameter int N_REQ = 2) (
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       last_owner,
    output logic [1:0]       winner,
    output logic             any
);
    logic [3:0] req_pad;
    logic [1:0] idx;
    // Walk from farthest to nearest so the nearest requester overwrites last.
    always_comb begin
        req_pad = 4'(req);
        winner = 2'(REQ_FETCH);
        idx = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = 2'((int'(last_owner) + k) % N_REQ);
            if (req_pad[idx]) winner = idx;
        end
    end
    assign any = |req;
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin owner of the single SRAM port with read tagging.
// Optional forced rotation after MAX_BURST cycles when SRAM_ARB_FAIRNESS_EN is defined.
module sram_port_arbiter import sram_arb_pkg::*; #(
    parameter int N_REQ     = 2,
    parameter int READ_LAT  = 2,
    parameter int MAX_BURST = 64
) (
    input logic               clock,
    input logic               resetn,
    sram_port_arbiter_if.slave bus
);
    arb_state_type state;
    logic [1:0] last_owner, winner;
    logic any, owned, active, preempt;
    logic [3:0] req_pad, we_pad;
    logic [SRAM_ADDR_W-1:0] addr_a [4];
    logic [SRAM_DATA_W-1:0] data_a [4];
    arb_tag_t [READ_LAT-1:0] tags;

    sram_arb_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req(bus.req), .last_owner(last_owner), .winner(winner), .any(any)
    );

    always_comb begin
        req_pad = 4'(bus.req);
        we_pad = 4'(bus.req_we_n);
        for (int i = 0; i < 4; i++) begin
            addr_a[i] = '0;
            data_a[i] = '0;
        end
        for (int i = 0; i < N_REQ; i++) begin
            addr_a[i] = bus.req_address[i*SRAM_ADDR_W +: SRAM_ADDR_W];
            data_a[i] = bus.req_write_data[i*SRAM_DATA_W +: SRAM_DATA_W];
        end
    end

    assign owned = state == ARB_OWNED;
    assign active = owned && req_pad[bus.owner];
    assign bus.SRAM_address = active ? addr_a[bus.owner] : '0;
    assign bus.SRAM_we_n = active ? we_pad[bus.owner] : 1'b1;
    assign bus.SRAM_write_data = active ? data_a[bus.owner] : '0;

`ifdef SRAM_ARB_FAIRNESS_EN
    logic [6:0] burst_cnt;
    logic [3:0] lock_pad;
    assign lock_pad = 4'(bus.lock);
    // Fires on the edge that completes the MAX_BURST-th owned cycle.
    assign preempt = active && !lock_pad[bus.owner] && (req_pad & ~(4'b1 << bus.owner)) != '0
                     && burst_cnt >= 7'(MAX_BURST - 1);
    always_ff @(posedge clock) begin
        if (!resetn || (owned ? (!active || preempt) : any)) burst_cnt <= '0;
        else if (active && burst_cnt != '1) burst_cnt <= burst_cnt + 1'b1;
    end
`else
    localparam int unused_max_burst = MAX_BURST;
    logic unused_lock;
    assign preempt = 1'b0;
    assign unused_lock = ^bus.lock;
`endif

    // A release hands straight to the next winner; preemption goes via idle.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= ARB_IDLE;
            bus.gnt <= '0;
            bus.busy <= 1'b0;
            bus.owner <= 2'(REQ_FETCH);
            last_owner <= 2'(N_REQ - 1);
        end else if (any && !active) begin
            state <= ARB_OWNED;
            bus.gnt <= N_REQ'(1 << winner);
            bus.busy <= 1'b1;
            bus.owner <= winner;
            last_owner <= winner;
        end else if (owned && (!active || preempt)) begin
            state <= ARB_IDLE;
            bus.gnt <= '0;
            bus.busy <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) tags <= '0;
        else begin
            tags[0] <= '{valid: active && we_pad[bus.owner], owner: bus.owner};
            for (int i = 1; i < READ_LAT; i++) tags[i] <= tags[i-1];
        end
    end

    assign bus.rd_valid = tags[READ_LAT-1].valid ? N_REQ'(1 << tags[READ_LAT-1].owner) : '0;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: random and directed stimulus against a queue-based arbitration model.
module tb_sram_port_arbiter;
    import sram_arb_pkg::*;
    localparam int N = 3;
    localparam int RL = 2;
    localparam int MB = 8;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    sram_port_arbiter_if #(.N_REQ(N)) bus ();
    sram_port_arbiter #(.N_REQ(N), .READ_LAT(RL), .MAX_BURST(MB)) dut (
        .clock(clock), .resetn(resetn), .bus(bus)
    );

    typedef struct {
        logic [N-1:0]           gnt;
        logic                   busy;
        logic [1:0]             owner;
        logic [SRAM_ADDR_W-1:0] addr;
        logic                   we_n;
        logic [SRAM_DATA_W-1:0] data;
    } port_t;
    typedef struct {
        int due;
        int who;
    } rd_t;

    port_t exp_port[$];
    rd_t exp_rd[$];
    int checks = 0, failures = 0, cyc = 0;
    int rd_seen[N];
    int m_owner = -1, m_last = N - 1, m_burst = 0;
    int hold_len[N];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic bit_of(logic [N-1:0] v, int i);
        logic [N-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic logic [SRAM_ADDR_W-1:0] addr_of(int i);
        logic [N*SRAM_ADDR_W-1:0] t;
        t = bus.req_address >> (i * SRAM_ADDR_W);
        return t[SRAM_ADDR_W-1:0];
    endfunction

    function automatic logic [SRAM_DATA_W-1:0] data_of(int i);
        logic [N*SRAM_DATA_W-1:0] t;
        t = bus.req_write_data >> (i * SRAM_DATA_W);
        return t[SRAM_DATA_W-1:0];
    endfunction

    function automatic int rr_pick(int last);
        for (int k = 1; k <= N; k++)
            if (bit_of(bus.req, (last + k) % N)) return (last + k) % N;
        return -1;
    endfunction

    // Model of the arbitration rules: predicts this cycle's outputs, then moves ownership.
    task automatic model();
        port_t e;
        logic act;
        int w;
        e.gnt = m_owner >= 0 ? N'(1) << m_owner : '0;
        e.busy = m_owner >= 0;
        e.owner = m_owner >= 0 ? 2'(m_owner) : 2'd0;
        act = m_owner >= 0 && bit_of(bus.req, m_owner);
        e.addr = act ? addr_of(m_owner) : '0;
        e.we_n = act ? bit_of(bus.req_we_n, m_owner) : 1'b1;
        e.data = act ? data_of(m_owner) : '0;
        exp_port.push_back(e);
        if (!resetn) begin
            while (exp_rd.size() > 0 && exp_rd[$].due > cyc) void'(exp_rd.pop_back());
            m_owner = -1;
            m_last = N - 1;
            m_burst = 0;
            return;
        end
        if (act && e.we_n) exp_rd.push_back('{cyc + RL, m_owner});
        if (m_owner < 0) begin
            w = rr_pick(m_last);
            if (w >= 0) begin
                m_owner = w;
                m_last = w;
                m_burst = 0;
            end
        end else if (!act) begin
            w = rr_pick(m_owner);
            m_owner = w;
            if (w >= 0) m_last = w;
            m_burst = 0;
        end else begin
            m_burst = m_burst < 127 ? m_burst + 1 : 127;
`ifdef SRAM_ARB_FAIRNESS_EN
            if (m_burst >= MB && !bit_of(bus.lock, m_owner) && (bus.req & ~(N'(1) << m_owner)) != '0) begin
                m_last = m_owner;
                m_owner = -1;
                m_burst = 0;
            end
`endif
        end
    endtask

    // Monitor: compares every cycle's port state and every read-valid strobe.
    initial begin
        port_t e;
        rd_t r;
        logic [N-1:0] want;
        forever begin
            @(negedge clock);
            #1;
            if (exp_port.size() > 0) begin
                e = exp_port.pop_front();
                chk("grant", {bus.gnt, bus.busy, bus.busy ? bus.owner : 2'd0}, {e.gnt, e.busy, e.owner});
                chk("sram", {bus.SRAM_address, bus.SRAM_we_n, bus.SRAM_write_data}, {e.addr, e.we_n, e.data});
            end
            want = '0;
            while (exp_rd.size() > 0 && exp_rd[0].due <= cyc) begin
                r = exp_rd.pop_front();
                want |= N'(1) << r.who;
            end
            if (want != '0 || bus.rd_valid !== '0) chk("rd_valid", bus.rd_valid, want);
            for (int i = 0; i < N; i++) if (bus.rd_valid[i] === 1'b1) rd_seen[i]++;
        end
    end

    task automatic tick();
        @(negedge clock);
        model();
        @(posedge clock);
        #1;
    endtask

    task automatic scramble();
        for (int i = 0; i < N; i++) begin
            bus.req_address[i*SRAM_ADDR_W +: SRAM_ADDR_W] = SRAM_ADDR_W'($urandom);
            bus.req_write_data[i*SRAM_DATA_W +: SRAM_DATA_W] = SRAM_DATA_W'($urandom);
        end
        bus.req_we_n = N'($urandom);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        int base, n;
        logic [N-1:0] r;
        bus.req = '0;
        bus.lock = '0;
        scramble();
        @(posedge clock);
        #1;
        do_reset();
        chk("reset_outs", {bus.gnt, bus.busy, bus.owner, bus.SRAM_address, bus.SRAM_we_n, bus.SRAM_write_data, bus.rd_valid},
            {N'(0), 1'b0, 2'd0, 18'd0, 1'b1, 16'd0, N'(0)});

        // Single requester, four reads at 0x100..0x103.
        scramble();
        bus.req = N'(1) << REQ_FETCH;
        bus.req_we_n[0] = 1'b1;
        tick();
        chk("t1_gnt", bus.gnt, N'(1));
        base = rd_seen[0];
        for (int a = 0; a < 4; a++) begin
            scramble();
            bus.req_address[SRAM_ADDR_W-1:0] = SRAM_ADDR_W'(32'h100 + a);
            bus.req_we_n[0] = 1'b1;
            tick();
        end
        bus.req = '0;
        repeat (4) tick();
        chk("t1_reads", 64'(rd_seen[0] - base), 64'd4);
        chk("t1_idle", {bus.SRAM_address, bus.SRAM_we_n}, {18'd0, 1'b1});

        // Contention after reset, read straddling handoff, then rotation.
        do_reset();
        scramble();
        bus.req = (N'(1) << REQ_FETCH) | (N'(1) << REQ_WRITE);
        bus.req_we_n = 3'b101;
        tick();
        chk("t2_first", bus.gnt, 3'b001);
        base = rd_seen[1];
        tick();
        tick();
        bus.req[0] = 1'b0;
        tick();
        chk("t2_handoff", bus.gnt, 3'b010);
        repeat (3) tick();
        bus.req[1] = 1'b0;
        tick();
        tick();
        chk("t2_no_rd1", 64'(rd_seen[1] - base), 64'd0);
        bus.req = 3'b011;
        tick();
        chk("t2_rotate", bus.gnt, 3'b001);
        bus.req = '0;
        repeat (2) tick();

        // Reset mid-burst with reads in flight.
        bus.req = 3'b001;
        bus.req_we_n = 3'b111;
        repeat (3) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        base = rd_seen[0];
        chk("t3_reset_outs", {bus.gnt, bus.busy, bus.owner, bus.SRAM_address, bus.SRAM_we_n, bus.SRAM_write_data, bus.rd_valid},
            {N'(0), 1'b0, 2'd0, 18'd0, 1'b1, 16'd0, N'(0)});
        bus.req = '0;
        repeat (4) tick();
        chk("t3_dropped", 64'(rd_seen[0] - base), 64'd0);

`ifdef SRAM_ARB_FAIRNESS_EN
        do_reset();
        bus.req = 3'b011;
        bus.lock = '0;
        tick();
        n = 0;
        while (bus.gnt[0] && n < 20) begin
            n++;
            tick();
        end
        chk("t4_burst", 64'(n), 64'(MB));
        chk("t4_gap", bus.gnt, 3'b000);
        tick();
        chk("t4_next", bus.gnt, 3'b010);
        bus.req = '0;
        repeat (2) tick();
        do_reset();
        bus.req = 3'b011;
        bus.lock = 3'b001;
        tick();
        repeat (12) tick();
        chk("t4_lock", bus.gnt, 3'b001);
        bus.req = '0;
        bus.lock = '0;
        repeat (2) tick();
`endif

        // Randomized traffic with occasional resets and locks.
        for (int c = 0; c < 1500; c++) begin
            r = bus.req;
            for (int i = 0; i < N; i++) begin
                if (r[i]) begin
                    hold_len[i]--;
                    if (hold_len[i] <= 0) r[i] = 1'b0;
                end else if ($urandom % 4 == 0) begin
                    r[i] = 1'b1;
                    hold_len[i] = int'($urandom_range(1, 14));
                end
            end
            bus.req = r;
            if ($urandom % 16 == 0) bus.lock = N'($urandom);
            resetn = ($urandom % 300) != 0;
            scramble();
            tick();
        end
        resetn = 1'b1;
        bus.req = '0;
        repeat (6) tick();
        chk("drain", 64'(exp_rd.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
